sha3_pad_tx: RTL and testbench

// - Feeder for the Keccak permutation core (perm): turns a byte-serial message into SHA3-256 padded rate blocks.
// - Drives perm's load interface (pushin/dix/din) with 8 x 200-bit slices of the 1600-bit state.
// - Packs bytes little-endian into a 136-byte rate buffer and applies the 0x06 ... 0x80 pad.
// - Multi-block messages: every block is emitted with first/last markers. XOR with the chaining state is done downstream.

---
 rtl/sha3_pkg.sv | 21 ++
 rtl/sha3_rate_buf.sv | 61 ++++++
 rtl/sha3_pad_tx.sv | 144 ++++++++++++++
 tb/tb_sha3_pad_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Purpose : shared constants and state encoding for the SHA3-256 pad/feed block.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sha3_pkg;

  localparam int RATE_BYTES = 136;
  localparam int RATE_BITS  = RATE_BYTES * 8;
  localparam int SLICE_W    = 200;
  localparam int NSLICE     = 8;

  localparam logic [7:0] PAD_DS  = 8'h06;   // SHA3 domain bits plus first pad bit
  localparam logic [7:0] PAD_END = 8'h80;   // final pad bit in the last rate byte

  typedef enum logic [1:0] {
    FILL,
    PAD,
    SEND,
    GAP
  } pad_state_t;

endpackage

// File: rtl/sha3_rate_buf.sv
// Purpose : 136-byte rate buffer with byte write, pad XOR, sync clear and 200-bit slice read.
// Latency : writes/pad/clear take effect at the next edge; slice read is combinational from the register.
// Backpressure: none; the controller sequences all accesses.
// Ports   : clk; clr (sync clear, wins over everything); wr_en/wr_idx/wr_dat (byte write);
//           pad_en/pad_idx (XOR 0x06 at pad_idx and 0x80 at byte 135); sidx -> slice.
module sha3_rate_buf
  import sha3_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [7:0]         wr_idx,
  input  logic [7:0]         wr_dat,
  input  logic               pad_en,
  input  logic [7:0]         pad_idx,
  input  logic [2:0]         sidx,
  output logic [SLICE_W-1:0] slice
);

  logic [RATE_BYTES-1:0][7:0] mem;
  logic [RATE_BYTES-1:0][7:0] mem_n;
  logic [RATE_BITS-1:0]       flat;

  // Both pad XORs land on the same byte when pad_idx is 135, giving 0x86.
  always_comb begin
    mem_n = mem;
    if (wr_en) begin
      mem_n[wr_idx] = wr_dat;
    end
    if (pad_en) begin
      mem_n[pad_idx]        = mem_n[pad_idx] ^ PAD_DS;
      mem_n[RATE_BYTES-1]   = mem_n[RATE_BYTES-1] ^ PAD_END;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else begin
      mem <= mem_n;
    end
  end

  // Byte j occupies rate bits 8j+7:8j (little-endian packing).
  assign flat = mem;

  // Slice 5 carries the 88 top rate bits; slices 6-7 are capacity and stay zero.
  always_comb begin
    slice = '0;
    case (sidx)
      3'd0:    slice = flat[0*SLICE_W +: SLICE_W];
      3'd1:    slice = flat[1*SLICE_W +: SLICE_W];
      3'd2:    slice = flat[2*SLICE_W +: SLICE_W];
      3'd3:    slice = flat[3*SLICE_W +: SLICE_W];
      3'd4:    slice = flat[4*SLICE_W +: SLICE_W];
      3'd5:    slice = SLICE_W'(flat[RATE_BITS-1:5*SLICE_W]);
      default: slice = '0;
    endcase
  end

endmodule

// File: rtl/sha3_pad_tx.sv
// Purpose : packs a byte stream into SHA3-256 padded rate blocks and feeds them to perm as 8 x 200-bit slices.
// Latency : last byte accepted in cycle t -> pad at t+1 -> slice 0 at t+2; full non-final block -> slice 0 at t+1.
// Backpressure: msg_rdy is low outside FILL (pad, 8 send cycles, BLK_GAP idle cycles); perm cannot stall the slices.
// Ports   : clk, reset (sync, active-low); msg_vld/msg_rdy/msg_byte/msg_last/msg_keep (byte input);
//           pushin/dix/din (slice output), blk_first/blk_last (block markers, valid with pushin).
module sha3_pad_tx
  import sha3_pkg::*;
#(
  parameter int BLK_GAP = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               msg_vld,
  output logic               msg_rdy,
  input  logic [7:0]         msg_byte,
  input  logic               msg_last,
  input  logic               msg_keep,
  output logic               pushin,
  output logic [2:0]         dix,
  output logic [SLICE_W-1:0] din,
  output logic               blk_first,
  output logic               blk_last
);

  localparam int GW = (BLK_GAP > 1) ? $clog2(BLK_GAP) : 1;

  pad_state_t state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [2:0]    sidx, sidx_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          pad_flag, pad_n;     // current block gets the pad (it is the message's last block)
  logic          pad_pend, pend_n;    // a padding-only block is owed after this full block
  logic          first_flag, first_n;
  logic          rdy_q;

  logic               accept;
  logic               wr_en, pad_en, clr_gap;
  logic [SLICE_W-1:0] slice;

  assign accept = msg_vld & rdy_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sidx_n  = sidx;
    gap_n   = gap_cnt;
    pad_n   = pad_flag;
    pend_n  = pad_pend;
    first_n = first_flag;
    wr_en   = 1'b0;
    pad_en  = 1'b0;
    clr_gap = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (msg_keep) begin
            wr_en = 1'b1;
            cnt_n = cnt + 8'd1;
          end
          if (msg_last) begin
            // A last byte that fills the block leaves no room for the pad:
            // this block goes out unpadded and a pad-only block follows.
            state_n = PAD;
            pend_n  = msg_keep && (cnt == 8'(RATE_BYTES-1));
            pad_n   = !(msg_keep && (cnt == 8'(RATE_BYTES-1)));
          end else if (msg_keep && (cnt == 8'(RATE_BYTES-1))) begin
            state_n = SEND;
            pad_n   = 1'b0;
          end
        end
      end
      PAD: begin
        pad_en  = pad_flag;
        state_n = SEND;
      end
      SEND: begin
        sidx_n = sidx + 3'd1;           // wraps back to 0 after slice 7
        if (sidx == 3'(NSLICE-1)) begin
          state_n = GAP;
          gap_n   = '0;
          first_n = pad_flag;
        end
      end
      GAP: begin
        gap_n = gap_cnt + 1'b1;
        if (gap_cnt == GW'(BLK_GAP-1)) begin
          clr_gap = 1'b1;
          cnt_n   = '0;
          gap_n   = '0;
          if (pad_pend) begin
            state_n = PAD;
            pend_n  = 1'b0;
            pad_n   = 1'b1;
          end else begin
            state_n = FILL;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FILL;
      cnt        <= '0;
      sidx       <= '0;
      gap_cnt    <= '0;
      pad_flag   <= 1'b0;
      pad_pend   <= 1'b0;
      first_flag <= 1'b1;
      rdy_q      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sidx       <= sidx_n;
      gap_cnt    <= gap_n;
      pad_flag   <= pad_n;
      pad_pend   <= pend_n;
      first_flag <= first_n;
      rdy_q      <= (state_n == FILL);
    end
  end

  sha3_rate_buf u_buf (
    .clk     (clk),
    .clr     (!reset || clr_gap),
    .wr_en   (wr_en),
    .wr_idx  (cnt),
    .wr_dat  (msg_byte),
    .pad_en  (pad_en),
    .pad_idx (cnt),
    .sidx    (sidx),
    .slice   (slice)
  );

  assign msg_rdy   = rdy_q;
  assign pushin    = (state == SEND);
  assign dix       = sidx;
  assign din       = pushin ? slice : '0;
  assign blk_first = pushin & first_flag;
  assign blk_last  = pushin & pad_flag;

endmodule

// File: tb/tb_sha3_pad_tx.sv
module tb_sha3_pad_tx;

  localparam int BLK_GAP = 24;
  localparam int RB      = 136;

  typedef struct packed {
    logic [199:0] din;
    logic [2:0]   dix;
    logic         first;
    logic         last;
  } exp_t;

  localparam logic [199:0] P80   = 200'h80 << 80;
  localparam logic [199:0] P86   = 200'h86 << 80;
  localparam logic [199:0] ONES5 = {112'b0, {88{1'b1}}};

  logic         clk, reset;
  logic         msg_vld, msg_rdy, msg_last, msg_keep;
  logic [7:0]   msg_byte;
  logic         pushin, blk_first, blk_last;
  logic [2:0]   dix;
  logic [199:0] din;

  int   checks, errors, cyc;
  exp_t expq[$];
  exp_t mout[$];
  bit   have_s7, prev_push;
  int   s7_cyc;
  logic [2:0] prev_dix;

  sha3_pad_tx #(.BLK_GAP(BLK_GAP)) dut (
    .clk(clk), .reset(reset),
    .msg_vld(msg_vld), .msg_rdy(msg_rdy), .msg_byte(msg_byte),
    .msg_last(msg_last), .msg_keep(msg_keep),
    .pushin(pushin), .dix(dix), .din(din),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: SHA3 padding applied to the whole message, then split into rate blocks.
  function automatic void model_msg(input logic [7:0] m[$]);
    int len  = m.size();
    int nblk = len / RB + 1;
    logic [7:0]   blk [RB];
    logic [199:0] v;
    int   bn;
    exp_t e;
    mout.delete();
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < RB; j++) blk[j] = (b*RB + j < len) ? m[b*RB + j] : 8'h00;
      if (b == nblk - 1) begin
        blk[len % RB] ^= 8'h06;
        blk[RB-1]     ^= 8'h80;
      end
      for (int s = 0; s < 8; s++) begin
        v = '0;
        for (int k = 0; k < 200; k++) begin
          bn = 200*s + k;
          if (bn < RB*8) v[k] = blk[bn/8][bn%8];
        end
        e.din = v; e.dix = 3'(s); e.first = (b == 0); e.last = (b == nblk - 1);
        mout.push_back(e);
      end
    end
  endfunction

  task automatic compare_cycle();
    exp_t e;
    if (reset) begin
      if (pushin) begin
        checks++;
        if (msg_rdy) begin
          errors++; $display("FAIL rdy_in_send: msg_rdy=%0b want 0", msg_rdy);
        end
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL unexpected_slice: dix=%0d din=%h want no slice", dix, din);
        end else begin
          e = expq.pop_front();
          if (dix !== e.dix || din !== e.din || blk_first !== e.first || blk_last !== e.last) begin
            errors++;
            $display("FAIL slice: got dix=%0d first=%0b last=%0b din=%h want dix=%0d first=%0b last=%0b din=%h",
                     dix, blk_first, blk_last, din, e.dix, e.first, e.last, e.din);
          end
        end
        if (dix == 3'd0 && have_s7) begin
          checks++;
          if (cyc - s7_cyc - 1 < BLK_GAP) begin
            errors++; $display("FAIL blk_gap: got %0d idle cycles want >= %0d", cyc - s7_cyc - 1, BLK_GAP);
          end
        end
        if (dix != 3'd0) begin
          checks++;
          if (!(prev_push && prev_dix == dix - 3'd1)) begin
            errors++; $display("FAIL slice_seq: dix=%0d prev_push=%0b prev_dix=%0d", dix, prev_push, prev_dix);
          end
        end
        if (dix == 3'd7) begin have_s7 = 1'b1; s7_cyc = cyc; end
      end
      prev_push = pushin;
      prev_dix  = dix;
    end else begin
      expq.delete();
      have_s7   = 1'b0;
      prev_push = 1'b0;
    end
  endtask

  task automatic beat(input logic [7:0] b, input bit l, input bit k, output int acc);
    int n = 0;
    msg_vld = 1'b1; msg_byte = b; msg_last = l; msg_keep = k;
    while (!msg_rdy && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) begin
      errors++; $display("FAIL rdy_timeout: msg_rdy=%0b want 1 within 2000 cycles", msg_rdy);
    end
    acc = cyc;
    @(posedge clk); #1;
    msg_vld = 1'b0; msg_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit term, input bit chk_lat, input bit hold);
    int acc = 0;
    int len = m.size();
    bit use_term = term || (len == 0);
    model_msg(m);
    foreach (mout[i]) expq.push_back(mout[i]);
    for (int i = 0; i < len; i++) begin
      if (!hold && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      beat(m[i], (i == len - 1) && !use_term, 1'b1, acc);
    end
    if (use_term) beat(8'h00, 1'b1, 1'b0, acc);
    if (chk_lat && (use_term || (len % RB) != 0)) begin
      @(posedge clk); #1;
      checks++;
      if (!(pushin && dix == 3'd0 && cyc == acc + 2)) begin
        errors++; $display("FAIL latency: pushin=%0b dix=%0d cycle=%0d want slice0 at %0d", pushin, dix, cyc, acc + 2);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(expq.size() == 0 && msg_rdy) && n < 1000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 1000) begin
      errors++; $display("FAIL drain: %0d slices outstanding, msg_rdy=%0b want 0 and 1", expq.size(), msg_rdy);
    end
  endtask

  task automatic pin(input string name, input logic [199:0] got, input logic [199:0] want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  logic [7:0] m[$];
  logic [7:0] t1[$];
  int n;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    have_s7 = 1'b0; prev_push = 1'b0; prev_dix = '0; s7_cyc = 0;
    reset = 1'b0; msg_vld = 1'b0; msg_byte = '0; msg_last = 1'b0; msg_keep = 1'b0;
    fork
      forever begin @(negedge clk); compare_cycle(); end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    pin("rst_msg_rdy", 200'(msg_rdy), '0);
    pin("rst_pushin",  200'(pushin), '0);
    pin("rst_dix",     200'(dix), '0);
    pin("rst_din",     din, '0);
    pin("rst_first",   200'(blk_first), '0);
    pin("rst_last",    200'(blk_last), '0);
    reset = 1'b1;
    pin("rdy_before_edge", 200'(msg_rdy), '0);
    @(posedge clk); #1;
    pin("rdy_after_release", 200'(msg_rdy), 200'd1);

    // Pin the reference model against hand-computed blocks
    t1 = '{8'h61, 8'h62, 8'h63, 8'h0a};
    model_msg(t1);
    pin("model_t1_nblk", 200'(mout.size()), 200'd8);
    pin("model_t1_s0", mout[0].din, 200'h60a636261);
    pin("model_t1_s3", mout[3].din, '0);
    pin("model_t1_s5", mout[5].din, P80);
    m = {};
    model_msg(m);
    pin("model_empty_s0", mout[0].din, 200'h06);
    pin("model_empty_s5", mout[5].din, P80);
    for (int i = 0; i < 135; i++) m.push_back(8'h00);
    model_msg(m);
    pin("model_135_s0", mout[0].din, '0);
    pin("model_135_s5", mout[5].din, P86);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'hff);
    model_msg(m);
    pin("model_136_nblk", 200'(mout.size()), 200'd16);
    pin("model_136_s0", mout[0].din, {200{1'b1}});
    pin("model_136_s5", mout[5].din, ONES5);
    pin("model_136_b2s0", mout[8].din, 200'h06);
    pin("model_136_b2_first", 200'(mout[8].first), '0);

    // Directed messages against the DUT
    send_msg(t1, 1'b0, 1'b1, 1'b0);
    m = {};
    send_msg(m, 1'b1, 1'b1, 1'b0);
    m = {};
    for (int i = 0; i < 135; i++) m.push_back(8'h00);
    send_msg(m, 1'b0, 1'b1, 1'b0);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'hff);
    send_msg(m, 1'b0, 1'b0, 1'b1);

    // Source holds valid across SEND/GAP; next message follows back-to-back
    m = {};
    for (int i = 0; i < 140; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b0, 1'b0, 1'b1);
    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b0, 1'b1, 1'b1);

    // Terminator-only final beat, and an exact two-block message
    m = {};
    for (int i = 0; i < 10; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b1, 1'b1, 1'b0);
    m = {};
    for (int i = 0; i < 272; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b0, 1'b0, 1'b0);

    // Random messages
    for (int r = 0; r < 6; r++) begin
      m = {};
      n = $urandom_range(0, 300);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
      send_msg(m, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end
    wait_idle();

    // Reset in the middle of a block, then resend
    send_msg(t1, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!(pushin && dix == 3'd3) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL reach_dix3: pushin=%0b dix=%0d want 1 and 3", pushin, dix);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    pin("midrst_pushin", 200'(pushin), '0);
    pin("midrst_rdy", 200'(msg_rdy), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_msg(t1, 1'b0, 1'b1, 1'b0);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
